stack_sequencer: RTL and testbench

- Control stage directly upstream of the 8-bit push/pop stack unit.
- Converts CPU control-flow requests (CALL, RET, interrupt entry, RETI) into single-cycle push_enable/pop_enable strobes.
- Collects popped bytes and hands the CPU a PC (and optionally a flags value) to load.
- Detects stack overflow, stack underflow and missing-pop-response, and reports each as a fault instead of corrupting state.

---
 rtl/stack_sequencer_if.sv | 41 ++++
 rtl/stack_sequencer.sv | 162 ++++++++++++++++
 tb/tb_stack_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
// Request, stack-unit and PC/flags handoff signals of the stack sequencer.
interface stack_sequencer_if;
  logic       call_req;
  logic       ret_req;
  logic       int_req;
  logic       reti_req;
  logic [7:0] call_target;
  logic [7:0] current_pc;
  logic [7:0] flags_in;
  logic       stack_full;
  logic       stack_empty;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic       push_enable;
  logic       pop_enable;
  logic [7:0] push_data;
  logic       busy;
  logic       done;
  logic       pc_load;
  logic [7:0] pc_value;
  logic       flags_load;
  logic [7:0] flags_value;
  logic       fault;
  logic [1:0] fault_code;

  // Requester and stack-unit side.
  modport master (
    output call_req, ret_req, int_req, reti_req, call_target, current_pc, flags_in,
    output stack_full, stack_empty, pop_data, pop_valid,
    input  push_enable, pop_enable, push_data, busy, done, pc_load, pc_value,
    input  flags_load, flags_value, fault, fault_code
  );

  // Sequencer side.
  modport slave (
    input  call_req, ret_req, int_req, reti_req, call_target, current_pc, flags_in,
    input  stack_full, stack_empty, pop_data, pop_valid,
    output push_enable, pop_enable, push_data, busy, done, pc_load, pc_value,
    output flags_load, flags_value, fault, fault_code
  );
endinterface

// File: rtl/stack_sequencer.sv
// Turns CALL/RET/interrupt/RETI requests into push/pop strobes for the stack
// unit, collects popped bytes and hands the CPU a PC (and flags) to load.
// Overflow, underflow and missing pop responses end the sequence with a fault.
module stack_sequencer #(
  parameter logic [7:0]  INT_VECTOR  = 8'hF0,
  parameter int unsigned RET_OFFSET  = 1,
  parameter int unsigned POP_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  stack_sequencer_if.slave bus
);
  localparam int unsigned   CW        = (POP_TIMEOUT > 2) ? $clog2(POP_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(POP_TIMEOUT - 1);
  localparam logic [7:0]    RET_ADD   = 8'(RET_OFFSET);

  typedef enum logic [3:0] {
    IDLE, PUSH_A, PUSH_B, POP_A, WAIT_A, POP_B, WAIT_B, FINISH, FAULT
  } state_t;

  typedef enum logic [1:0] {OP_CALL, OP_INT, OP_RET, OP_RETI} op_t;

  state_t        state;
  op_t           op;
  logic [7:0]    addr_q;      // return address to push, or PC popped back
  logic [7:0]    target_q;
  logic [7:0]    flags_q;     // flags to push, or flags popped back
  logic [1:0]    pend_code;
  logic [CW-1:0] wait_cnt;

  logic       push_en_q, pop_en_q, busy_q, done_q, pc_load_q, flags_load_q, fault_q;
  logic [7:0] push_data_q, pc_value_q, flags_value_q;
  logic [1:0] fault_code_q;

  assign bus.push_enable = push_en_q;
  assign bus.pop_enable  = pop_en_q;
  assign bus.push_data   = push_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pc_load     = pc_load_q;
  assign bus.pc_value    = pc_value_q;
  assign bus.flags_load  = flags_load_q;
  assign bus.flags_value = flags_value_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;

  // Sequencer FSM; every output is registered from the state that decides it,
  // so strobes and busy appear one cycle after that state (busy stays high
  // through the done cycle and drops the cycle after).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op            <= OP_CALL;
      addr_q        <= '0;
      target_q      <= '0;
      flags_q       <= '0;
      pend_code     <= '0;
      wait_cnt      <= '0;
      push_en_q     <= 1'b0;
      pop_en_q      <= 1'b0;
      push_data_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_value_q    <= '0;
      flags_load_q  <= 1'b0;
      flags_value_q <= '0;
      fault_q       <= 1'b0;
      fault_code_q  <= '0;
    end else begin
      push_en_q    <= 1'b0;
      pop_en_q     <= 1'b0;
      done_q       <= 1'b0;
      pc_load_q    <= 1'b0;
      flags_load_q <= 1'b0;
      fault_q      <= 1'b0;
      busy_q       <= (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.int_req || bus.call_req || bus.ret_req || bus.reti_req) begin
            addr_q       <= bus.int_req ? bus.current_pc : bus.current_pc + RET_ADD;
            target_q     <= bus.call_target;
            flags_q      <= bus.flags_in;
            pend_code    <= '0;
            fault_code_q <= '0;
            if (bus.int_req) begin
              op    <= OP_INT;
              state <= PUSH_A;
            end else if (bus.call_req) begin
              op    <= OP_CALL;
              state <= PUSH_A;
            end else if (bus.ret_req) begin
              op    <= OP_RET;
              state <= POP_A;
            end else begin
              op    <= OP_RETI;
              state <= POP_A;
            end
          end
        end
        PUSH_A, PUSH_B: begin
          if (bus.stack_full) begin
            pend_code <= 2'd1;
            state     <= FAULT;
          end else begin
            push_en_q   <= 1'b1;
            push_data_q <= (state == PUSH_A) ? addr_q : flags_q;
            state       <= (state == PUSH_A && op == OP_INT) ? PUSH_B : FINISH;
          end
        end
        POP_A, POP_B: begin
          if (bus.stack_empty) begin
            pend_code <= 2'd2;
            state     <= FAULT;
          end else begin
            pop_en_q <= 1'b1;
            wait_cnt <= '0;
            state    <= (state == POP_A) ? WAIT_A : WAIT_B;
          end
        end
        WAIT_A, WAIT_B: begin
          if (bus.pop_valid) begin
            // RETI pops flags first (pushed last on interrupt entry), then PC.
            if (state == WAIT_A && op == OP_RETI) begin
              flags_q <= bus.pop_data;
              state   <= POP_B;
            end else begin
              addr_q <= bus.pop_data;
              state  <= FINISH;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            pend_code <= 2'd3;
            state     <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        FINISH: begin
          done_q    <= 1'b1;
          pc_load_q <= 1'b1;
          case (op)
            OP_CALL: pc_value_q <= target_q;
            OP_INT:  pc_value_q <= INT_VECTOR;
            default: pc_value_q <= addr_q;
          endcase
          if (op == OP_RETI) begin
            flags_load_q  <= 1'b1;
            flags_value_q <= flags_q;
          end
          state <= IDLE;
        end
        FAULT: begin
          done_q       <= 1'b1;
          fault_q      <= 1'b1;
          fault_code_q <= pend_code;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized bench for stack_sequencer against a transaction-level model of
// CALL/INT/RET/RETI sequences over a byte stack.
module tb_stack_sequencer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 4;
  localparam logic [7:0]  VEC   = 8'hF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_sequencer_if bus();

  stack_sequencer #(.INT_VECTOR(VEC), .RET_OFFSET(1), .POP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stack unit: absorbs pushes; answers a pop in the cycle after it is
  // requested unless muted.
  logic [7:0] stk[$];
  logic [7:0] push_log[$];
  int         pop_cnt  = 0;
  int         fill_cmd = 0;   // 1: empty the stack, 2: fill it to capacity
  bit         mute     = 1'b0;

  always @(negedge clk) begin
    bus.pop_valid = 1'b0;
    bus.pop_data  = 8'($urandom);
    if (fill_cmd == 1) stk.delete();
    else if (fill_cmd == 2) begin
      stk.delete();
      for (int unsigned i = 0; i < DEPTH; i++) stk.push_back(8'($urandom));
    end
    if (!rst) begin
      if (bus.push_enable) begin
        stk.push_back(bus.push_data);
        push_log.push_back(bus.push_data);
      end
      if (bus.pop_enable) begin
        pop_cnt++;
        if (!mute && stk.size() != 0) begin
          bus.pop_data  = stk.pop_back();
          bus.pop_valid = 1'b1;
        end
      end
    end
    bus.stack_full  = (stk.size() >= DEPTH);
    bus.stack_empty = (stk.size() == 0);
  end

  // Reference model: a sequence is a list of stack operations; each push or
  // pop request takes a cycle, an answered pop one more, an unanswered pop
  // POP_TIMEOUT more, and the closing done cycle one more.
  logic [7:0] m_stk[$];
  logic [7:0] m_push[$];
  logic [7:0] m_bytes[$];
  int         m_lat, m_code, m_pops;
  bit         m_mute;

  function automatic void m_push_byte(input logic [7:0] b);
    if (m_code != 0) return;
    m_lat++;
    if (m_stk.size() >= DEPTH) m_code = 1;
    else begin
      m_stk.push_back(b);
      m_push.push_back(b);
    end
  endfunction

  function automatic void m_pop_byte();
    if (m_code != 0) return;
    m_lat++;
    if (m_stk.size() == 0) m_code = 2;
    else begin
      m_pops++;
      if (m_mute) begin
        m_lat += TMO;
        m_code = 3;
      end else begin
        m_lat++;
        m_bytes.push_back(m_stk.pop_back());
      end
    end
  endfunction

  function automatic logic [63:0] out_vec();
    return {31'b0, bus.push_enable, bus.pop_enable, bus.push_data, bus.busy, bus.done,
            bus.pc_load, bus.pc_value, bus.flags_load, bus.flags_value, bus.fault, bus.fault_code};
  endfunction

  task automatic do_fill(input int cmd);
    @(negedge clk); #1;
    fill_cmd = cmd;
    @(negedge clk); #1;
    fill_cmd = 0;
  endtask

  // req bits: {int, call, ret, reti}; requests are raised for the acceptance
  // edge only, then replaced by random noise that must be ignored while busy.
  task automatic run_txn(input string name, input logic [3:0] req, input logic [7:0] pc,
                         input logic [7:0] tgt, input logic [7:0] flg, input bit mute_i);
    logic [7:0] exp_pc, exp_flags, d_pcv, d_flv;
    logic       d_pcl, d_fl, d_fault;
    logic [1:0] d_code;
    bit         is_reti;
    int         lat, base_push, base_pop, n_pcl;
    int         push_j[$];
    int         pop_j[$];
    @(negedge clk); #1;
    mute = mute_i;
    m_stk = stk;
    m_push.delete();
    m_bytes.delete();
    m_lat = 0; m_code = 0; m_pops = 0; m_mute = mute_i;
    exp_pc = 8'h00; exp_flags = 8'h00;
    is_reti = (req == 4'b0001);
    if (req[3]) begin
      m_push_byte(pc);
      m_push_byte(flg);
      exp_pc = VEC;
    end else if (req[2]) begin
      m_push_byte(pc + 8'd1);
      exp_pc = tgt;
    end else if (req[1]) begin
      m_pop_byte();
      if (m_bytes.size() > 0) exp_pc = m_bytes[0];
    end else begin
      m_pop_byte();
      m_pop_byte();
      if (m_bytes.size() == 2) begin
        exp_flags = m_bytes[0];
        exp_pc    = m_bytes[1];
      end
    end
    m_lat++;

    base_push = push_log.size();
    base_pop  = pop_cnt;
    {bus.int_req, bus.call_req, bus.ret_req, bus.reti_req} = req;
    bus.current_pc = pc; bus.call_target = tgt; bus.flags_in = flg;
    lat = -1; n_pcl = 0;
    d_pcl = 1'b0; d_fl = 1'b0; d_fault = 1'b0; d_code = '0; d_pcv = '0; d_flv = '0;
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk); #1;
      check($sformatf("%s.excl", name), bus.push_enable & bus.pop_enable, 0);
      if (bus.push_enable) push_j.push_back(j);
      if (bus.pop_enable) pop_j.push_back(j);
      if (bus.pc_load) n_pcl++;
      if (bus.done) begin
        lat = j;
        d_pcl = bus.pc_load; d_pcv = bus.pc_value; d_fl = bus.flags_load;
        d_flv = bus.flags_value; d_fault = bus.fault; d_code = bus.fault_code;
        {bus.int_req, bus.call_req, bus.ret_req, bus.reti_req} = 4'b0;
        break;
      end
      {bus.int_req, bus.call_req, bus.ret_req, bus.reti_req} = 4'($urandom);
      bus.current_pc = 8'($urandom); bus.call_target = 8'($urandom); bus.flags_in = 8'($urandom);
    end
    {bus.int_req, bus.call_req, bus.ret_req, bus.reti_req} = 4'b0;

    check($sformatf("%s.latency", name), lat, m_lat);
    check($sformatf("%s.fault", name), d_fault, m_code != 0);
    check($sformatf("%s.fault_code", name), d_code, m_code);
    check($sformatf("%s.pc_load", name), d_pcl, m_code == 0);
    check($sformatf("%s.n_pc_load", name), n_pcl, (m_code == 0) ? 1 : 0);
    if (m_code == 0) check($sformatf("%s.pc_value", name), d_pcv, exp_pc);
    check($sformatf("%s.flags_load", name), d_fl, is_reti && m_code == 0);
    if (is_reti && m_code == 0) check($sformatf("%s.flags_value", name), d_flv, exp_flags);
    check($sformatf("%s.n_push", name), push_log.size() - base_push, m_push.size());
    for (int i = 0; i < m_push.size() && i < push_log.size() - base_push && i < push_j.size(); i++) begin
      check($sformatf("%s.push_data%0d", name, i), push_log[base_push + i], m_push[i]);
      check($sformatf("%s.push_cycle%0d", name, i), push_j[i], i + 1);
    end
    check($sformatf("%s.n_pop", name), pop_cnt - base_pop, m_pops);
    for (int i = 0; i < m_pops && i < pop_j.size(); i++)
      check($sformatf("%s.pop_cycle%0d", name, i), pop_j[i], 1 + 2 * i);
    check($sformatf("%s.depth", name), stk.size(), m_stk.size());
    @(negedge clk); #1;
    check($sformatf("%s.busy_after", name), bus.busy, 0);
    check($sformatf("%s.done_after", name), bus.done, 0);
    check($sformatf("%s.code_held", name), bus.fault_code, m_code);
    mute = 1'b0;
  endtask

  initial begin
    int         hold_j[$];
    logic [6:0] strobes;
    int unsigned r;
    {bus.int_req, bus.call_req, bus.ret_req, bus.reti_req} = 4'b0;
    bus.current_pc = '0; bus.call_target = '0; bus.flags_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset.outputs", out_vec(), 0);
    rst = 1'b0;

    run_txn("call_10", 4'b0100, 8'h10, 8'h40, 8'h00, 1'b0);
    run_txn("call_wrap", 4'b0100, 8'hFF, 8'h33, 8'h00, 1'b0);
    run_txn("int_22", 4'b1000, 8'h22, 8'h77, 8'hA5, 1'b0);
    run_txn("reti", 4'b0001, 8'h90, 8'h00, 8'h00, 1'b0);
    do_fill(1);
    run_txn("ret_empty", 4'b0010, 8'h05, 8'h00, 8'h00, 1'b0);
    do_fill(2);
    run_txn("call_full", 4'b0100, 8'h06, 8'h60, 8'h00, 1'b0);
    run_txn("ret_timeout", 4'b0010, 8'h07, 8'h00, 8'h00, 1'b1);
    do_fill(1);
    run_txn("int_call", 4'b1100, 8'h44, 8'h55, 8'h3C, 1'b0);
    do_fill(2);
    run_txn("int_half_full", 4'b1000, 8'h12, 8'h00, 8'h34, 1'b0);

    // Reset while RETI waits for its first pop response.
    do_fill(2);
    mute = 1'b1;
    bus.reti_req = 1'b1;
    @(negedge clk); #1;
    bus.reti_req = 1'b0;
    @(negedge clk); #1;
    check("rst_mid.pop_enable", bus.pop_enable, 1);
    rst = 1'b1;
    #1;
    check("rst_mid.outputs", out_vec(), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    mute = 1'b0;
    strobes = '0;
    repeat (4) begin
      @(negedge clk); #1;
      strobes |= {bus.push_enable, bus.pop_enable, bus.done, bus.pc_load,
                  bus.flags_load, bus.fault, bus.busy};
    end
    check("rst_mid.quiet", strobes, 0);

    // A CALL request held high is re-accepted after one IDLE cycle each time.
    do_fill(1);
    bus.current_pc = 8'h30; bus.call_target = 8'h50; bus.call_req = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk); #1;
      if (bus.push_enable) hold_j.push_back(j);
      if (j == 7) bus.call_req = 1'b0;
    end
    check("hold.n_push", hold_j.size(), 3);
    for (int i = 0; i < hold_j.size() && i < 3; i++)
      check($sformatf("hold.push_cycle%0d", i), hold_j[i], 1 + 3 * i);

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) do_fill(1);
      else if (r == 1) do_fill(2);
      run_txn($sformatf("rand%0d", t), 4'($urandom_range(1, 15)), 8'($urandom),
              8'($urandom), 8'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
